// File: rtl/byte_unstriping.sv
// Byte unstriping: merges two byte lanes (lane 0 = even-order bytes, lane 1 = odd-order
// bytes) back into one stream. Each lane is buffered in its own DEPTH-entry FIFO, and a
// two-state merge FSM pops the lanes in strict alternation so inter-lane skew never
// reorders bytes. Bytes arriving at a full FIFO are dropped and flagged by a sticky overflow.
module byte_unstriping #(
  parameter int unsigned DEPTH = 4  // entries per lane FIFO, power of two, >= 2
) (
  input  logic                     clk_2f,
  input  logic                     reset,
  input  logic [7:0]               lane_0,
  input  logic                     valid_0,
  input  logic [7:0]               lane_1,
  input  logic                     valid_1,
  output logic [7:0]               data_out,
  output logic                     valid_out,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level_0,
  output logic [$clog2(DEPTH):0]   level_1
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [0:0] {StSel0, StSel1} state_e;

  // Lane-indexed views of the inputs so both FIFOs share one description.
  logic [7:0] lane_in [2];
  logic [1:0] valid_in;

  assign lane_in[0] = lane_0;
  assign lane_in[1] = lane_1;
  assign valid_in   = {valid_1, valid_0};

  logic [7:0]      mem_q    [2][DEPTH];
  logic [7:0]      mem_d    [2][DEPTH];
  logic [PtrW-1:0] wr_ptr_q [2];
  logic [PtrW-1:0] wr_ptr_d [2];
  logic [PtrW-1:0] rd_ptr_q [2];
  logic [PtrW-1:0] rd_ptr_d [2];
  logic [CntW-1:0] cnt_q    [2];
  logic [CntW-1:0] cnt_d    [2];

  logic [7:0] data_out_q, data_out_d;
  logic       valid_out_q, valid_out_d;
  logic       overflow_q, overflow_d;
  state_e     state_q, state_d;

  logic [1:0] pop;
  logic [1:0] push;
  logic [1:0] drop;
  logic [1:0] full;

  // Pop decisions use only the occupancy registered before this edge, so a byte
  // written on this edge can leave no earlier than the next one.
  always_comb begin
    pop    = '0;
    pop[0] = (state_q == StSel0) && (cnt_q[0] != '0);
    pop[1] = (state_q == StSel1) && (cnt_q[1] != '0);
  end

  // FIFO bookkeeping: push when there is room (a same-edge pop frees a slot), else drop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    push     = '0;
    drop     = '0;
    full     = '0;
    for (int l = 0; l < 2; l++) begin
      full[l] = (cnt_q[l] == CntW'(DEPTH));
      push[l] = valid_in[l] && (!full[l] || pop[l]);
      drop[l] = valid_in[l] && full[l] && !pop[l];
      if (push[l]) begin
        mem_d[l][wr_ptr_q[l]] = lane_in[l];
        wr_ptr_d[l]           = wr_ptr_q[l] + PtrW'(1);
      end
      if (pop[l]) begin
        rd_ptr_d[l] = rd_ptr_q[l] + PtrW'(1);
      end
      cnt_d[l] = cnt_q[l] + CntW'(push[l]) - CntW'(pop[l]);
    end
  end

  // Merge FSM: wait on the selected lane until it has a byte, never skipping ahead.
  always_comb begin
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    state_d     = state_q;
    overflow_d  = overflow_q | (|drop);
    case (state_q)
      StSel0: begin
        if (pop[0]) begin
          data_out_d  = mem_q[0][rd_ptr_q[0]];
          valid_out_d = 1'b1;
          state_d     = StSel1;
        end
      end
      StSel1: begin
        if (pop[1]) begin
          data_out_d  = mem_q[1][rd_ptr_q[1]];
          valid_out_d = 1'b1;
          state_d     = StSel0;
        end
      end
      default: state_d = StSel0;
    endcase
  end

  // Control state and registered outputs, synchronously reset.
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      for (int l = 0; l < 2; l++) begin
        wr_ptr_q[l] <= '0;
        rd_ptr_q[l] <= '0;
        cnt_q[l]    <= '0;
      end
      data_out_q  <= 8'h00;
      valid_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      state_q     <= StSel0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      overflow_q  <= overflow_d;
      state_q     <= state_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      mem_q <= mem_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign overflow  = overflow_q;
  assign level_0   = cnt_q[0];
  assign level_1   = cnt_q[1];

endmodule

// File: doc/byte_unstriping.md
BYTE_UNSTRIPING -- requirements
Module: byte_unstriping

Interface
REQ-001 Parameter: DEPTH, default 4, entries per lane FIFO (power of two, >=2).
REQ-002 clk_2f  input  1  byte clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high; sampled on rising clk_2f.
REQ-004 lane_0  input  8  byte from lane 0 (even-order bytes of the stream).
REQ-005 valid_0  input  1  lane_0 holds a byte to accept this cycle.
REQ-006 lane_1  input  8  byte from lane 1 (odd-order bytes of the stream).
REQ-007 valid_1  input  1  lane_1 holds a byte to accept this cycle.
REQ-008 data_out  output  8  merged byte stream, registered.
REQ-009 valid_out  output  1  data_out carries a new byte this cycle, registered.
REQ-010 overflow  output  1  sticky: a byte was dropped due to a full lane FIFO.
REQ-011 level_0, level_1  output  clog2(DEPTH)+1 each  current FIFO occupancy, registered.

Function
REQ-012 Each lane SHALL have an independent DEPTH-entry FIFO with write pointer, read pointer and count; pointers wrap modulo DEPTH.
REQ-013 On a rising edge with valid_x=1 and FIFO_x not full, lane_x SHALL be written at wr_ptr_x, and wr_ptr_x incremented.
REQ-014 Merge FSM SHALL have two states: SEL0 (next byte comes from lane 0) and SEL1 (next byte from lane 1).
REQ-015 In SEL0 with count_0>0: pop FIFO_0 head into data_out, valid_out=1 next edge, move to SEL1.
REQ-016 In SEL0 with count_0=0: valid_out=0, data_out holds previous value, stay in SEL0; same rule mirrored for SEL1/lane 1.
REQ-017 The FSM SHALL never skip a lane; strict order lane0, lane1, lane0, ... is preserved regardless of inter-lane skew.
REQ-018 Pop decision SHALL use only entries stored before the current edge; a byte accepted on edge k appears on data_out no earlier than edge k+1 (minimum latency 1 cycle).
REQ-019 Simultaneous push and pop on the same FIFO SHALL leave count unchanged, both pointers advance; allowed even when full.
REQ-020 Push to a full FIFO with no pop on that FIFO in the same cycle SHALL drop the incoming byte, leave FIFO unchanged, and set overflow=1.
REQ-021 overflow SHALL remain 1 until reset; it does not alter merge behaviour.
REQ-022 count_x SHALL range 0..DEPTH; level_x reflects count_x after the edge.
REQ-023 Sustained throughput: with both lanes delivering one byte every two cycles, valid_out SHALL be 1 every cycle once both FIFOs are non-empty.
REQ-024 Lane words with valid_x=0 SHALL be ignored entirely.

Reset
REQ-025 With reset=1 on a rising edge: data_out=8'h00, valid_out=0, overflow=0, level_0=level_1=0, all pointers 0, FSM=SEL0.
REQ-026 Reset mid-operation SHALL discard all stored bytes; lane inputs presented during the reset cycle are not captured.
REQ-027 First cycle after reset deassertion SHALL accept lane inputs normally; first output byte is taken from lane 0.

Verification
REQ-028 Aligned lanes: lane_0=01,03,05,07,09,0B and lane_1=02,04,06,08,0A,0C, valid both high on every second edge -> data_out 01..0C in order, valid_out contiguous after fill, overflow=0.
REQ-029 Skew: lane_1 delayed 3 cycles vs lane_0 (same data as REQ-028) -> identical output sequence 01..0C; valid_out low while SEL1 waits on empty FIFO_1.
REQ-030 Lane-0 starvation: valid_0=0 permanently, lane_1 pushes 5 bytes with DEPTH=4 -> valid_out stays 0, level_1=4, fifth byte dropped, overflow=1.
REQ-031 Gap in input: both valids drop for 2 lane slots after byte 04, then resume at 05/06 -> valid_out=0 for the gap, data_out holds 04, sequence continues 05,06.
REQ-032 Full with simultaneous push/pop: FIFO_0 full (level_0=4), FSM in SEL0, valid_0=1 with byte AA -> head popped, AA stored, level_0 stays 4, overflow remains 0.
REQ-033 Reset mid-stream: assert reset for one edge after 6 bytes pushed -> outputs per REQ-025 next cycle; subsequent pushes 10/11 produce data_out 10,11.
